branch_resolve_unit: RTL

//  Parametrised, pipelined successor to the combinational branch compare stage.

---
 rtl/branch_resolve_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Single registered stage that resolves BRANCH/JAL/JALR and flags mispredicts, with valid/ready on both sides.
// Optional macro BRANCH_STATS_EN adds saturating resolved/mispredict counters.
module branch_resolve_unit #(
  parameter int XLEN = 32
`ifdef BRANCH_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_kind,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_pred_taken,
  input  logic [XLEN-1:0] in_pred_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
  output logic            out_mispredict,
  output logic            out_illegal,
  output logic            out_misaligned
`ifdef BRANCH_STATS_EN
  , output logic [CNT_W-1:0] stat_resolved
  , output logic [CNT_W-1:0] stat_mispred
`endif
);

  typedef enum logic [1:0] {
    KIND_BRANCH = 2'b00,
    KIND_JAL    = 2'b01,
    KIND_JALR   = 2'b10,
    KIND_NONE   = 2'b11
  } kind_e;

  logic            r_valid;
  logic            r_taken;
  logic [XLEN-1:0] r_target;
  logic [XLEN-1:0] r_link;
  logic            r_mispredict;
  logic            r_illegal;
  logic            r_misaligned;

  logic            w_accept;
  logic [XLEN-1:0] w_sum_pc;
  logic [XLEN-1:0] w_sum_rs;
  logic            w_taken;
  logic [XLEN-1:0] w_target;
  logic            w_illegal;
  logic            w_mispredict;
  logic            w_misaligned;

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_sum_pc = in_pc + in_imm;
  assign w_sum_rs = in_rs1 + in_imm;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_taken   = 1'b0;
    w_target  = '0;
    w_illegal = 1'b0;
    case (kind_e'(in_kind))
      KIND_BRANCH: begin
        w_target = w_sum_pc;
        case (in_funct3)
          3'b000:  w_taken = (in_rs1 == in_rs2);
          3'b001:  w_taken = (in_rs1 != in_rs2);
          3'b100:  w_taken = ($signed(in_rs1) <  $signed(in_rs2));
          3'b101:  w_taken = ($signed(in_rs1) >= $signed(in_rs2));
          3'b110:  w_taken = (in_rs1 <  in_rs2);
          3'b111:  w_taken = (in_rs1 >= in_rs2);
          default: w_illegal = 1'b1;
        endcase
      end
      KIND_JAL: begin
        w_taken  = 1'b1;
        w_target = w_sum_pc;
      end
      KIND_JALR: begin
        w_taken  = 1'b1;
        w_target = {w_sum_rs[XLEN-1:1], 1'b0};
      end
      default: ;
    endcase
  end

  assign w_mispredict = (w_taken != in_pred_taken) || (w_taken && (w_target != in_pred_target));
  assign w_misaligned = w_taken && (w_target[1:0] != 2'b00);

  // NOTE: sequential state is written only with non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_taken      <= 1'b0;
      r_target     <= '0;
      r_link       <= '0;
      r_mispredict <= 1'b0;
      r_illegal    <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid      <= 1'b1;
      r_taken      <= w_taken;
      r_target     <= w_target;
      r_link       <= in_pc + XLEN'(4);
      r_mispredict <= w_mispredict;
      r_illegal    <= w_illegal;
      r_misaligned <= w_misaligned;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid      = r_valid;
  assign out_taken      = r_taken;
  assign out_target     = r_target;
  assign out_link       = r_link;
  assign out_mispredict = r_mispredict;
  assign out_illegal    = r_illegal;
  assign out_misaligned = r_misaligned;

`ifdef BRANCH_STATS_EN
  logic             r_is_ctrl;
  logic [CNT_W-1:0] r_stat_resolved;
  logic [CNT_W-1:0] r_stat_mispred;
  logic             w_out_hs;

  assign w_out_hs = r_valid && out_ready;

  // Counters see only reset; a flush must not erase history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_is_ctrl       <= 1'b0;
      r_stat_resolved <= '0;
      r_stat_mispred  <= '0;
    end else begin
      if (w_accept && !flush) r_is_ctrl <= (kind_e'(in_kind) != KIND_NONE);
      if (w_out_hs && r_is_ctrl && (r_stat_resolved != '1))
        r_stat_resolved <= r_stat_resolved + CNT_W'(1);
      if (w_out_hs && r_mispredict && (r_stat_mispred != '1))
        r_stat_mispred <= r_stat_mispred + CNT_W'(1);
    end
  end

  assign stat_resolved = r_stat_resolved;
  assign stat_mispred  = r_stat_mispred;
`else
  // Statistics disabled: no counter state or ports.
`endif

endmodule
